fifo_ctl: RTL
=============

# fifo_ctl

Parametrised synchronous FIFO; successor to the basic single-mode FIFO. Adds selectable read mode (standard or first-word-fall-through), a fill-level output, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Used as the general buffering element between datapath stages running on one clock, such as packetiser input and capture buffering.

## Interface
- DATA_WIDTH, 64: word width in bits, ≥1.
- DEPTH, 1024: storage words; power of two, ≥2.
- FWFT, 0: 0 = standard read mode, 1 = first-word-fall-through.
- AF_THRESH, 1020: `almost_full` asserts when count ≥ AF_THRESH; 1..DEPTH.
- AE_THRESH, 4: `almost_empty` asserts when count ≤ AE_THRESH; 0..DEPTH-1.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; has priority over `we`/`re`.
- we  in  1  write request.
- din  in  DATA_WIDTH  write data.
- re  in  1  read request (pop).
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  standard mode: one-cycle pulse when `dout` is updated. FWFT mode: equals `!empty`.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count ≤ AE_THRESH.
- almost_full  out  1  count ≥ AF_THRESH.
- count  out  $clog2(DEPTH)+1  words stored and not yet popped.
- overflow  out  1  sticky; write attempted while full.
- underflow  out  1  sticky; read attempted while empty.

## Operation
- Accepted write: `we && !full`. Stores `din` at the write pointer; the write pointer advances modulo DEPTH.
- Accepted read: `re && !empty`. The read pointer advances modulo DEPTH.
- `full` and `empty` are evaluated on the current registered count before the edge.
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- Count update per edge:
  - +1 for an accepted write only.
  - −1 for an accepted read only.
  - Unchanged when both or neither are accepted.
  - Never leaves 0..DEPTH.
- Pointer arithmetic is $clog2(DEPTH) bits with natural wrap. Entry DEPTH-1 is followed by entry 0.
- Standard mode (FWFT=0):
  - An accepted read registers `mem[raddr]` into `dout` at that edge.
  - `dout_valid` is high for exactly the following cycle.
  - `dout` holds its value otherwise.
- FWFT mode (FWFT=1):
  - `dout` continuously presents the head word, a combinational memory read at `raddr`.
  - `re` acknowledges and pops the head word.
  - `dout` is don't-care while empty.
- Error flags:
  - `overflow` sets on `we && full`.
  - `underflow` sets on `re && empty`.
  - Both flags clear only on reset or `clear`.
- `clear`:
  - Pointers and count go to 0; `overflow`, `underflow` and `dout_valid` go to 0.
  - `we`/`re` in the same cycle are ignored and do not set the error flags.
  - `dout` register and memory contents are retained.
- Reset, asserted asynchronously at any time including mid-transfer:
  - count=0, pointers=0, `dout`=0, `dout_valid`=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - Memory contents are not reset.

## Timing
- All status outputs are functions of the registered count and are valid one cycle after the causing edge.
- Write-to-readable: a word written at edge N makes `empty`=0 after edge N and can be popped at edge N+1.
- Standard read latency: `re` accepted at edge N gives `dout`/`dout_valid` valid after edge N.
- FWFT: the head word is visible in the same cycle `empty` deasserts.
- Throughput: one write and one read per cycle sustained. At count=DEPTH with both `we` and `re`, only the read completes.
- `full` deasserts the cycle after the first read from full. `empty` deasserts the cycle after the first write into empty.

## Test plan
Benches use DEPTH=8, AF_THRESH=6, AE_THRESH=1, DATA_WIDTH=16.

- Fill and drain, FWFT=0:
  - Write 0x0001..0x0008 on consecutive cycles. Require full=1, count=8 and almost_full from count=6 onward.
  - Read 8 on consecutive cycles. Require `dout` 0x0001..0x0008, each with a one-cycle `dout_valid`. End state empty=1, count=0.
- Overflow/underflow:
  - With the FIFO full, write 0xDEAD. Require overflow=1, count stays 8 and 0xDEAD is never read.
  - Drain the FIFO, then pulse `re` once more. Require underflow=1.
  - Pulse `clear`. Require both flags at 0.
- Simultaneous read and write:
  - At count=4, assert `we`+`re` for 20 cycles with an incrementing pattern. Require count to stay at 4 and output order to match input order across pointer wrap.
  - At count=8, assert `we`+`re`. Require count=7 and overflow=1.
- FWFT=1:
  - Write 0x00AA at edge N. Require empty=0 and `dout`=0x00AA after edge N with no `re`.
  - Pop it with `re`. Require empty=1 next cycle.
  - At count=0, assert `we`+`re` together. Require the read rejected, underflow=1 and count=1.
- Mid-operation reset and clear:
  - At count=5, drop `rst_n` asynchronously between edges. Require all outputs at their reset values immediately.
  - Repeat the setup with `clear` plus `we` in the same cycle. Require count=0 next cycle and overflow/underflow both 0.

Source files
------------

// File: rtl/fifo_ctl.sv
// Single-clock FIFO with selectable standard/FWFT read mode, fill level,
// programmable almost flags, sticky error flags and synchronous flush.
module fifo_ctl #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 1020,
    parameter int AE_THRESH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         waddr;
    logic [AW-1:0]         raddr;
    logic [CW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_acc;
    logic                  rd_acc;

    // Handshake: we is a request that completes at the edge only when !full
    // (and no clear); re likewise completes only when !empty. full/empty come
    // from the registered count, so a same-cycle pop never frees room for a
    // push at full, and a same-cycle push never feeds a pop at empty.
    assign wr_acc = we && !full  && !clear;
    assign rd_acc = re && !empty && !clear;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = (count <= CW'(AE_THRESH));
    assign almost_full  = (count >= CW'(AF_THRESH));

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + CW'(1);
        else if (rd_acc && !wr_acc)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                waddr <= waddr + AW'(1);
            if (rd_acc)
                raddr <= raddr + AW'(1);
            count <= count_nxt;
            if (we && full)
                overflow <= 1'b1;
            if (re && empty)
                underflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[waddr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout       = mem[raddr];
            assign dout_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dv_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else if (clear) begin
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc)
                        dout_q <= mem[raddr];
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dv_q;
        end
    endgenerate

endmodule
